// File: rtl/note_sched_pkg.sv
// Shared state encoding, screen geometry and index-width helper for the note highway scheduler.
package note_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADVANCE = 3'd1,
        ST_FETCH   = 3'd2,
        ST_SPAWN   = 3'd3,
        ST_JUDGE   = 3'd4
    } state_e;

    localparam int unsigned SCREEN_H = 32'd480;
    localparam int unsigned HIT_Y    = 32'd350;
    localparam int unsigned HIT_H    = 32'd20;
    localparam int unsigned NOTE_H   = 32'd50;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 32'd1) ? 32'($clog2(n)) : 32'd1;
    endfunction

endpackage

// File: rtl/note_slot_alloc.sv
// Per-lane priority encoder: index of the lowest set candidate bit plus a found flag.
module note_slot_alloc
    import note_sched_pkg::*;
#(
    parameter int unsigned SLOTS = 4,
    parameter int unsigned SW    = idx_width(SLOTS)
) (
    input  logic [SLOTS-1:0] cand_i,
    output logic [SW-1:0]    idx_o,
    output logic             found_o
);

    logic [SLOTS-1:0] low_s;

    // Isolate the lowest set bit so the OR-encode below sees a one-hot vector.
    assign low_s   = cand_i & (~cand_i + SLOTS'(1'b1));
    assign found_o = |cand_i;

    // Encode the one-hot lowest candidate into a slot index.
    always_comb begin
        idx_o = {SW{1'b0}};
        for (int i = 0; i < int'(SLOTS); i++) begin
            idx_o = idx_o | (low_s[i] ? SW'(i) : {SW{1'b0}});
        end
    end

endmodule

// File: rtl/note_scheduler.sv
// Note slot owner for the lane highway: advances, spawns from the chart ROM and judges strums.
// Build option: define LOOP_CHART_EN to wrap the chart address instead of stopping at the last row.
module note_scheduler
    import note_sched_pkg::*;
#(
    parameter int unsigned NUM_LANES      = 4,
    parameter int unsigned SLOTS_PER_LANE = 4,
    parameter int unsigned Y_WIDTH        = 10,
    parameter int unsigned CHART_AW       = 6,
    parameter int unsigned SPAWN_GAP      = 100
) (
    input  logic                                        clk_i,
    input  logic                                        reset_i,
    input  logic                                        tick_i,
    input  logic                                        run_i,
    input  logic [3:0]                                  speed_i,
    input  logic                                        strum_i,
    input  logic [NUM_LANES-1:0]                        buttons_i,
    output logic [CHART_AW-1:0]                         chart_addr_o,
    output logic                                        chart_rd_o,
    input  logic [NUM_LANES-1:0]                        chart_data_i,
    output logic [NUM_LANES*SLOTS_PER_LANE-1:0]         note_valid_o,
    output logic [NUM_LANES*SLOTS_PER_LANE*Y_WIDTH-1:0] note_y_o,
    output logic [NUM_LANES-1:0]                        hit_pulse_o,
    output logic [NUM_LANES-1:0]                        miss_pulse_o,
    output logic                                        chart_done_o,
    output logic                                        busy_o
);

    localparam int unsigned NS  = NUM_LANES * SLOTS_PER_LANE;
    localparam int unsigned LW  = idx_width(NUM_LANES);
    localparam int unsigned SW  = idx_width(SLOTS_PER_LANE);
    localparam int unsigned IW  = idx_width(NS);
    localparam int unsigned YW1 = Y_WIDTH + 32'd1;
    localparam int unsigned DW  = idx_width(SPAWN_GAP + 32'd16);

    state_e                state_q;
    logic [NS-1:0]         valid_q;
    logic [Y_WIDTH-1:0]    y_q [NS];
    logic [IW-1:0]         walk_q;
    logic [DW-1:0]         dist_q;
    logic                  tick_pend_q;
    logic                  strum_pend_q;
    logic [NUM_LANES-1:0]  btn_q;
    logic [NUM_LANES-1:0]  miss_acc_q;
    logic [NUM_LANES-1:0]  hit_q;
    logic [NUM_LANES-1:0]  miss_q;
    logic                  chart_rd_q;
    logic [CHART_AW-1:0]   addr_q;
    logic                  done_q;

    logic [YW1-1:0]        sum_s;
    logic                  retire_now_s;
    logic [LW-1:0]         walk_lane_s;
    logic [NUM_LANES-1:0]  miss_acc_s;
    logic [DW-1:0]         dist_sum_s;
    logic [NS-1:0]         win_s;
    logic                  any_in_s;
    state_e                after_pass_s;
    logic [NUM_LANES-1:0]  alloc_found_s;
    logic [NUM_LANES-1:0]  judge_found_s;
    logic [IW-1:0]         alloc_slot_s [NUM_LANES];
    logic [IW-1:0]         judge_slot_s [NUM_LANES];

    // Position sum is one bit wider so a note crossing the bottom cannot wrap back on screen.
    assign sum_s        = {1'b0, y_q[walk_q]} + YW1'(speed_i);
    assign retire_now_s = valid_q[walk_q] && (sum_s >= YW1'(SCREEN_H));
    assign walk_lane_s  = LW'(walk_q / IW'(SLOTS_PER_LANE));
    assign miss_acc_s   = miss_acc_q | (retire_now_s ? (NUM_LANES'(1'b1) << walk_lane_s)
                                                     : {NUM_LANES{1'b0}});
    assign dist_sum_s   = dist_q + DW'(speed_i);
    assign any_in_s     = |(valid_q & win_s);
    assign after_pass_s = (strum_pend_q || strum_i) ? ST_JUDGE : ST_IDLE;

    for (genvar i = 0; i < NS; i++) begin : g_slot
        assign win_s[i] = ({1'b0, y_q[i]} < YW1'(HIT_Y + HIT_H)) &&
                          (({1'b0, y_q[i]} + YW1'(NOTE_H)) > YW1'(HIT_Y));
        assign note_y_o[i*Y_WIDTH +: Y_WIDTH] = y_q[i];
    end

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        logic [SW-1:0] a_idx_s;
        logic [SW-1:0] j_idx_s;

        note_slot_alloc #(.SLOTS(SLOTS_PER_LANE), .SW(SW)) u_alloc (
            .cand_i  (~valid_q[l*SLOTS_PER_LANE +: SLOTS_PER_LANE]),
            .idx_o   (a_idx_s),
            .found_o (alloc_found_s[l])
        );

        note_slot_alloc #(.SLOTS(SLOTS_PER_LANE), .SW(SW)) u_judge (
            .cand_i  (valid_q[l*SLOTS_PER_LANE +: SLOTS_PER_LANE] & win_s[l*SLOTS_PER_LANE +: SLOTS_PER_LANE]),
            .idx_o   (j_idx_s),
            .found_o (judge_found_s[l])
        );

        assign alloc_slot_s[l] = IW'(l * SLOTS_PER_LANE) + IW'(a_idx_s);
        assign judge_slot_s[l] = IW'(l * SLOTS_PER_LANE) + IW'(j_idx_s);
    end

    // Pass sequencer: pending-event latches, slot walk, chart fetch/spawn and strum judging.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            valid_q      <= {NS{1'b0}};
            for (int i = 0; i < int'(NS); i++) begin
                y_q[i] <= {Y_WIDTH{1'b0}};
            end
            walk_q       <= {IW{1'b0}};
            dist_q       <= {DW{1'b0}};
            tick_pend_q  <= 1'b0;
            strum_pend_q <= 1'b0;
            btn_q        <= {NUM_LANES{1'b0}};
            miss_acc_q   <= {NUM_LANES{1'b0}};
            hit_q        <= {NUM_LANES{1'b0}};
            miss_q       <= {NUM_LANES{1'b0}};
            chart_rd_q   <= 1'b0;
            addr_q       <= {CHART_AW{1'b0}};
            done_q       <= 1'b0;
        end else begin
            hit_q      <= {NUM_LANES{1'b0}};
            miss_q     <= {NUM_LANES{1'b0}};
            chart_rd_q <= 1'b0;

            // The newest strum overrides an unjudged one, even in the JUDGE cycle itself.
            if (strum_i) begin
                strum_pend_q <= 1'b1;
                btn_q        <= buttons_i;
            end else if (state_q == ST_JUDGE) begin
                strum_pend_q <= 1'b0;
            end
            if (tick_i && run_i && (state_q != ST_IDLE)) begin
                tick_pend_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (tick_pend_q || (tick_i && run_i)) begin
                        state_q     <= ST_ADVANCE;
                        walk_q      <= {IW{1'b0}};
                        miss_acc_q  <= {NUM_LANES{1'b0}};
                        tick_pend_q <= 1'b0;
                    end else if (strum_pend_q || strum_i) begin
                        state_q <= ST_JUDGE;
                    end
                end
                ST_ADVANCE: begin
                    if (retire_now_s) begin
                        valid_q[walk_q] <= 1'b0;
                    end else if (valid_q[walk_q]) begin
                        y_q[walk_q] <= sum_s[Y_WIDTH-1:0];
                    end
                    miss_acc_q <= miss_acc_s;
                    if (walk_q == IW'(NS - 32'd1)) begin
                        miss_q <= miss_acc_s;
                        if (done_q) begin
                            state_q <= after_pass_s;
                        end else if (dist_sum_s >= DW'(SPAWN_GAP)) begin
                            dist_q     <= dist_sum_s - DW'(SPAWN_GAP);
                            chart_rd_q <= 1'b1;
                            state_q    <= ST_FETCH;
                        end else begin
                            dist_q  <= dist_sum_s;
                            state_q <= after_pass_s;
                        end
                    end else begin
                        walk_q <= walk_q + IW'(1'b1);
                    end
                end
                ST_FETCH: begin
                    state_q <= ST_SPAWN;
                end
                ST_SPAWN: begin
                    for (int l = 0; l < int'(NUM_LANES); l++) begin
                        if (chart_data_i[l] && alloc_found_s[l]) begin
                            valid_q[alloc_slot_s[l]] <= 1'b1;
                            y_q[alloc_slot_s[l]]     <= {Y_WIDTH{1'b0}};
                        end
                    end
                    if (addr_q == {CHART_AW{1'b1}}) begin
`ifdef LOOP_CHART_EN
                        addr_q <= {CHART_AW{1'b0}};
`else
                        done_q <= 1'b1;
`endif
                    end else begin
                        addr_q <= addr_q + CHART_AW'(1'b1);
                    end
                    state_q <= after_pass_s;
                end
                ST_JUDGE: begin
                    if (any_in_s) begin
                        for (int l = 0; l < int'(NUM_LANES); l++) begin
                            if (btn_q[l] && judge_found_s[l]) begin
                                valid_q[judge_slot_s[l]] <= 1'b0;
                                hit_q[l]                 <= 1'b1;
                            end else if (btn_q[l]) begin
                                miss_q[l] <= 1'b1;
                            end
                        end
                    end
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign chart_addr_o = addr_q;
    assign chart_rd_o   = chart_rd_q;
    assign note_valid_o = valid_q;
    assign hit_pulse_o  = hit_q;
    assign miss_pulse_o = miss_q;
    assign chart_done_o = done_q;
    assign busy_o       = (state_q != ST_IDLE);

endmodule
